pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Central stall/flush controller for the 5-stage RV64 pipeline. It collects hazard and wait requests from IF, ID, EX and MEM and produces the 5-bit stall_ctrl vector consumed by pc_reg and every pipeline register (if_id, id_ex, ex_mem, mem_wb). It also sequences the EX multi-cycle unit (mul/div) with a start/done handshake. It turns EX branch redirects into flushes, including discard of an in-flight fetch.

Parameters:
MC_TIMEOUT, 64, max cycles MC_BUSY may last before mc_err pulses and the FSM returns to MC_IDLE
CNT_W, 64, width of the stall performance counter

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
if_wait  in  1  IF fetch not yet returned (instruction bus not ready)
if_req_out  in  1  IF has a fetch outstanding on the bus this cycle
id_load_use  in  1  ID detected load-use hazard
ex_mc_op  in  1  EX holds a mul/div op needing the multi-cycle unit
mc_done  in  1  multi-cycle unit result valid (1-cycle pulse)
mem_wait  in  1  MEM data access not complete
ex_redirect  in  1  EX resolved taken branch/jump mispredict
stall_ctrl  out  5  [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb; 1 = Stop
flush_ifid  out  1  load bubble into if_id
flush_idex  out  1  load bubble into id_ex
pc_redirect  out  1  pc_reg loads EX target this cycle
fetch_discard  out  1  IF drops the next returned instruction
mc_start  out  1  1-cycle start pulse to multi-cycle unit
mc_err  out  1  1-cycle pulse on multi-cycle timeout
stall_cnt  out  CNT_W  cycles in which stall_ctrl != 0

Behaviour:
- Reset (rst=0, async): stall_ctrl=5'b00000, all pulses 0, stall_cnt=0, MC FSM=MC_IDLE, fetch FSM=F_NORM.
- stall_ctrl is combinational from inputs and state. A request at stage s sets bits [s:0]. The pipeline register just above the highest stopped bit inserts a bubble.
- Stage index: IF=1, ID=2, EX=3, MEM=4.
- Priority, highest wins: mem_wait -> 5'b11111 (mem_wb bubbles itself); ex stall -> 5'b01111; id_load_use -> 5'b00111; if_wait -> 5'b00011.
- ex stall = ex_mc_op && !(MC_BUSY && mc_done).
- MC FSM:
  - MC_IDLE: ex_mc_op && !mem_wait -> mc_start=1, go to MC_BUSY, clear timeout counter.
  - MC_BUSY: mc_done -> MC_IDLE; the EX stall drops the same cycle so the result advances.
  - MC_BUSY: counter reaches MC_TIMEOUT-1 -> mc_err=1, MC_IDLE.
  - mc_start never fires while mem_wait=1.
  - mc_done while in MC_IDLE is ignored.
- Redirect: acted on only when stall_ctrl[3]=0 (EX not frozen). Then pc_redirect=1, flush_ifid=1, flush_idex=1.
  - Redirect overrides id_load_use and if_wait for that cycle: stall_ctrl[2:0]=0 so the PC advances to the target.
  - While EX is frozen, redirect is held by EX and acted on later; the controller needs no latch.
- Fetch FSM: redirect acted on while if_req_out=1 -> F_DISCARD. In F_DISCARD, fetch_discard=1 until the first cycle with if_wait=0, then F_NORM. A second redirect while in F_DISCARD stays in F_DISCARD.
- stall_cnt increments by 1 each cycle stall_ctrl != 0. It wraps modulo 2^CNT_W.
- Reset mid-operation returns both FSMs to idle immediately. No mc_start is issued on the first cycle after reset release unless ex_mc_op=1.

Decomposition:
- Shared defines file: Stop/NoStop, the stall_ctrl bit indices, the four stall masks (5'b11111, 5'b01111, 5'b00111, 5'b00011), and the FSM state encodings.
- One natural sub-module: mc_seq, holding the MC FSM plus timeout counter and producing mc_start, mc_err and the EX stall term.

Test Plan:
- Reset with all requests high, then release -> stall_ctrl=11111 (mem_wait dominates), stall_cnt=0 at release; async assert mid-cycle clears outputs without waiting for clk.
- ex_mc_op=1, mc_done pulsed 8 cycles after mc_start -> mc_start exactly one cycle; stall_ctrl=01111 for 8 cycles, 00000 in the mc_done cycle; stall_cnt=8.
- id_load_use=1 and ex_redirect=1 in the same cycle, EX not stalled -> stall_ctrl=00000, pc_redirect=flush_ifid=flush_idex=1.
- ex_redirect=1 while mem_wait=1 for 3 cycles -> no pc_redirect for 3 cycles, stall_ctrl=11111; redirect acted on in cycle 4.
- Redirect with if_req_out=1, then if_wait=1 for 2 cycles -> fetch_discard=1 for 3 cycles, dropping on the cycle with if_wait=0.
- ex_mc_op=1 with MC_TIMEOUT=4 and no mc_done -> mc_err pulses on the 4th MC_BUSY cycle; FSM in MC_IDLE; a new mc_start follows next cycle since ex_mc_op is still 1.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller: stop polarity,
// stall_ctrl bit positions, per-stage stall masks and FSM states.
package pipe_stall_ctrl_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int SC_W      = 5;
    localparam int SC_PC     = 0;
    localparam int SC_IF_ID  = 1;
    localparam int SC_ID_EX  = 2;
    localparam int SC_EX_MEM = 3;
    localparam int SC_MEM_WB = 4;

    // A request at stage s freezes everything at and below s.
    localparam logic [SC_W-1:0] MASK_MEM  = 5'b11111;
    localparam logic [SC_W-1:0] MASK_EX   = 5'b01111;
    localparam logic [SC_W-1:0] MASK_ID   = 5'b00111;
    localparam logic [SC_W-1:0] MASK_IF   = 5'b00011;
    localparam logic [SC_W-1:0] MASK_NONE = 5'b00000;

    typedef enum logic {MC_IDLE, MC_BUSY}  mc_state_t;
    typedef enum logic {F_NORM, F_DISCARD} fetch_state_t;

endpackage

// File: rtl/pipe_stall_ctrl_mc_seq.sv
// Multi-cycle (mul/div) sequencer: start/done handshake with a timeout,
// and the EX stall term that holds the op until its result is back.
module pipe_stall_ctrl_mc_seq
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic ex_mc_op,
    input  logic mc_done,
    input  logic mem_wait,
    output logic mc_start,
    output logic mc_err,
    output logic ex_stall
);

    localparam int TW = $clog2(MC_TIMEOUT) + 1;
    localparam logic [TW-1:0] LAST = TW'(MC_TIMEOUT - 1);

    mc_state_t     state, state_nxt;
    logic [TW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MC_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mc_start  = 1'b0;
        mc_err    = 1'b0;
        // Stall releases in the done cycle so the result moves on immediately.
        ex_stall  = ex_mc_op && !(state == MC_BUSY && mc_done);
        case (state)
            MC_IDLE: begin
                if (ex_mc_op && !mem_wait) begin
                    mc_start  = 1'b1;
                    state_nxt = MC_BUSY;
                    cnt_nxt   = '0;
                end
            end
            MC_BUSY: begin
                if (mc_done) begin
                    state_nxt = MC_IDLE;
                end else if (cnt == LAST) begin
                    mc_err    = 1'b1;
                    state_nxt = MC_IDLE;
                end else begin
                    cnt_nxt = cnt + TW'(1);
                end
            end
            default: state_nxt = MC_IDLE;
        endcase
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: stall priority,
// branch redirect/flush, in-flight fetch discard and a stall-cycle counter.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_wait,
    input  logic             if_req_out,
    input  logic             id_load_use,
    input  logic             ex_mc_op,
    input  logic             mc_done,
    input  logic             mem_wait,
    input  logic             ex_redirect,
    output logic [SC_W-1:0]  stall_ctrl,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             pc_redirect,
    output logic             fetch_discard,
    output logic             mc_start,
    output logic             mc_err,
    output logic [CNT_W-1:0] stall_cnt
);

    logic            ex_stall, mc_start_raw, mc_err_raw;
    logic [SC_W-1:0] base_mask;
    logic            redirect_ok;
    fetch_state_t    f_state, f_nxt;

    pipe_stall_ctrl_mc_seq #(.MC_TIMEOUT(MC_TIMEOUT)) u_mc_seq (
        .clk      (clk),
        .rst      (rst),
        .ex_mc_op (ex_mc_op),
        .mc_done  (mc_done),
        .mem_wait (mem_wait),
        .mc_start (mc_start_raw),
        .mc_err   (mc_err_raw),
        .ex_stall (ex_stall)
    );

    always_comb begin
        base_mask = MASK_NONE;
        if (mem_wait)         base_mask = MASK_MEM;
        else if (ex_stall)    base_mask = MASK_EX;
        else if (id_load_use) base_mask = MASK_ID;
        else if (if_wait)     base_mask = MASK_IF;
    end

    // A frozen EX keeps holding its redirect, so it is simply acted on later.
    assign redirect_ok = ex_redirect && (base_mask[SC_EX_MEM] == NO_STOP);

    // Outputs are forced quiet while reset is asserted, independent of clk.
    assign stall_ctrl    = !rst ? MASK_NONE : (redirect_ok ? MASK_NONE : base_mask);
    assign pc_redirect   = rst && redirect_ok;
    assign flush_ifid    = rst && redirect_ok;
    assign flush_idex    = rst && redirect_ok;
    assign fetch_discard = rst && (f_state == F_DISCARD);
    assign mc_start      = rst && mc_start_raw;
    assign mc_err        = rst && mc_err_raw;

    always_comb begin
        f_nxt = f_state;
        case (f_state)
            F_NORM:    if (redirect_ok && if_req_out) f_nxt = F_DISCARD;
            F_DISCARD: if (!redirect_ok && !if_wait)  f_nxt = F_NORM;
            default:   f_nxt = F_NORM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_state   <= F_NORM;
            stall_cnt <= '0;
        end else begin
            f_state <= f_nxt;
            if (|stall_ctrl) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with a behavioural reference model
// checked every cycle plus hand-computed literal expectations.
module tb_pipe_stall_ctrl;

    localparam int TO = 10;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_wait, if_req_out, id_load_use, ex_mc_op, mc_done, mem_wait, ex_redirect;
    logic [4:0]    stall_ctrl;
    logic          flush_ifid, flush_idex, pc_redirect, fetch_discard, mc_start, mc_err;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit m_busy, m_disc;
    int m_age, m_cnt;
    logic [4:0] e_stall;
    logic e_redir, e_disc, e_start, e_err;

    pipe_stall_ctrl #(.MC_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .if_wait(if_wait), .if_req_out(if_req_out), .id_load_use(id_load_use),
        .ex_mc_op(ex_mc_op), .mc_done(mc_done), .mem_wait(mem_wait),
        .ex_redirect(ex_redirect),
        .stall_ctrl(stall_ctrl), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .pc_redirect(pc_redirect), .fetch_discard(fetch_discard),
        .mc_start(mc_start), .mc_err(mc_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clr();
        if_wait = 0; if_req_out = 0; id_load_use = 0; ex_mc_op = 0;
        mc_done = 0; mem_wait = 0; ex_redirect = 0;
    endtask

    task automatic mreset();
        m_busy = 0; m_disc = 0; m_age = 0; m_cnt = 0;
    endtask

    // Outputs from the rules: the highest requesting stage s stops bits [s:0].
    task automatic eval();
        int  lvl;
        bit  exs;
        e_stall = 0; e_redir = 0; e_disc = 0; e_start = 0; e_err = 0;
        if (rst) begin
            exs = ex_mc_op && !(m_busy && mc_done);
            lvl = mem_wait ? 4 : exs ? 3 : id_load_use ? 2 : if_wait ? 1 : 0;
            e_stall = (lvl == 0) ? 5'd0 : 5'((1 << (lvl + 1)) - 1);
            e_redir = ex_redirect && (lvl < 3);
            if (e_redir) e_stall = 0;
            e_start = !m_busy && ex_mc_op && !mem_wait;
            e_err   = m_busy && !mc_done && (m_age == TO - 1);
            e_disc  = m_disc;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        eval();
        chk("stall_ctrl",    stall_ctrl,    e_stall);
        chk("pc_redirect",   pc_redirect,   e_redir);
        chk("flush_ifid",    flush_ifid,    e_redir);
        chk("flush_idex",    flush_idex,    e_redir);
        chk("fetch_discard", fetch_discard, e_disc);
        chk("mc_start",      mc_start,      e_start);
        chk("mc_err",        mc_err,        e_err);
        chk("stall_cnt",     stall_cnt,     64'(m_cnt));
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst) begin
            eval();
            if (e_stall != 0) m_cnt = (m_cnt + 1) % (1 << CW);
            if (e_start) begin
                m_busy = 1; m_age = 0;
            end else if (m_busy) begin
                if (mc_done || e_err) m_busy = 0;
                else m_age++;
            end
            if (e_redir && (m_disc || if_req_out)) m_disc = 1;
            else if (m_disc && !if_wait)           m_disc = 0;
        end
        #1;
    endtask

    initial begin
        mreset();
        // reset with every request high
        if_wait = 1; if_req_out = 1; id_load_use = 1; ex_mc_op = 1;
        mc_done = 1; mem_wait = 1; ex_redirect = 1;
        sample();
        chk("rst_stall", stall_ctrl, 5'b00000);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_start", mc_start, 0);
        adv();
        rst = 1;
        sample();
        chk("rel_stall", stall_ctrl, 5'b11111);
        chk("rel_cnt", stall_cnt, 0);
        chk("rel_redir", pc_redirect, 0);
        adv();
        sample();
        chk("rel_cnt1", stall_cnt, 1);
        #1 rst = 0; mreset();
        #1;
        chk("async_stall", stall_ctrl, 5'b00000);
        chk("async_cnt", stall_cnt, 0);
        adv();
        clr(); rst = 1;
        sample(); adv();

        // multi-cycle op, done 8 cycles after start
        ex_mc_op = 1;
        for (int i = 0; i < 8; i++) begin
            sample();
            chk("mc_start_once", mc_start, (i == 0));
            chk("mc_stall", stall_ctrl, 5'b01111);
            adv();
        end
        mc_done = 1;
        sample();
        chk("mc_done_stall", stall_ctrl, 5'b00000);
        chk("mc_done_start", mc_start, 0);
        adv();
        clr();
        sample();
        chk("mc_cnt8", stall_cnt, 8);
        adv();

        // redirect overrides load-use
        id_load_use = 1; ex_redirect = 1;
        sample();
        chk("lu_redir_stall", stall_ctrl, 5'b00000);
        chk("lu_redir_pc", pc_redirect, 1);
        chk("lu_redir_fifid", flush_ifid, 1);
        chk("lu_redir_fidex", flush_idex, 1);
        adv(); clr();

        // redirect held while MEM waits
        mem_wait = 1; ex_redirect = 1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("mw_redir_pc", pc_redirect, 0);
            chk("mw_redir_stall", stall_ctrl, 5'b11111);
            adv();
        end
        mem_wait = 0;
        sample();
        chk("mw_redir_late", pc_redirect, 1);
        adv(); clr();

        // redirect with outstanding fetch -> discard
        ex_redirect = 1; if_req_out = 1;
        sample();
        chk("fd_redir", pc_redirect, 1);
        chk("fd_pre", fetch_discard, 0);
        adv(); clr();
        if_wait = 1;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("fd_wait", fetch_discard, 1);
            chk("fd_wait_stall", stall_ctrl, 5'b00011);
            adv();
        end
        if_wait = 0;
        sample();
        chk("fd_ret", fetch_discard, 1);
        adv();
        sample();
        chk("fd_done", fetch_discard, 0);
        adv();

        // second redirect during discard keeps discarding
        ex_redirect = 1; if_req_out = 1;
        sample(); adv();
        if_req_out = 0;
        sample();
        chk("fd_second", fetch_discard, 1);
        adv(); clr();
        sample();
        chk("fd_second_hold", fetch_discard, 1);
        adv();
        sample();
        chk("fd_second_end", fetch_discard, 0);
        adv();

        // timeout: err on the TO-th busy cycle, restart next cycle
        ex_mc_op = 1;
        for (int i = 0; i < TO + 2; i++) begin
            sample();
            chk("to_err", mc_err, (i == TO));
            chk("to_start", mc_start, (i == 0 || i == TO + 1));
            adv();
        end
        mc_done = 1;
        sample();
        chk("to_done_stall", stall_ctrl, 5'b00000);
        adv(); clr();

        // stray done while idle
        mc_done = 1;
        sample();
        chk("idle_done_stall", stall_ctrl, 5'b00000);
        chk("idle_done_start", mc_start, 0);
        adv(); clr();

        // mixed traffic against the model
        for (int i = 0; i < 300; i++) begin
            if_wait     = ($urandom_range(0, 3) == 0);
            if_req_out  = $urandom_range(0, 1);
            id_load_use = ($urandom_range(0, 4) == 0);
            ex_mc_op    = ($urandom_range(0, 3) == 0);
            mc_done     = ($urandom_range(0, 3) == 0);
            mem_wait    = ($urandom_range(0, 4) == 0);
            ex_redirect = ($urandom_range(0, 5) == 0);
            sample(); adv();
        end
        clr();

        // counter wrap
        rst = 0; mreset();
        sample(); adv();
        rst = 1; if_wait = 1;
        for (int i = 0; i < (1 << CW) + 2; i++) begin
            sample(); adv();
        end
        if_wait = 0;
        sample();
        chk("cnt_wrap", stall_cnt, 2);
        adv();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
